// File: rtl/countdown_pkg.sv
// countdown_pkg: shared state encoding and default width for the countdown block
package countdown_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam int DEFAULT_WIDTH = 4;
endpackage

// File: rtl/countdown_fsm.sv
// countdown_fsm: state sequencing and terminal-count pulse (COUNTDOWN_AUTO_RELOAD_EN keeps RUN after terminal edge)
module countdown_fsm
   import countdown_pkg::*;
(
   input  logic   CLK,
   input  logic   CLR,
   input  logic   EN,
   input  logic   LOAD,
   input  logic   d_zero,
   input  logic   q_one,
   output state_t state,
   output logic   TC,
   output logic   term
);
   state_t nxt;
   // next state; a LOAD always overrides the terminal edge, so term excludes it
   always_comb begin
      term = (state == RUN) && EN && q_one && !LOAD;
      nxt  = state;
      if (LOAD)
         nxt = d_zero ? DONE : RUN;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      else if (term)
         nxt = RUN;
`else
      else if (term)
         nxt = DONE;
`endif
   end
   // state and registered TC pulse, cleared asynchronously
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         state <= IDLE;
         TC    <= 1'b0;
      end else begin
         state <= nxt;
         TC    <= term;
      end
   end
endmodule

// File: rtl/countdown_4bit.sv
// countdown_4bit: loadable down-counter with terminal-count pulse (optional COUNTDOWN_AUTO_RELOAD_EN)
module countdown_4bit
   import countdown_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             CLK,
   input  logic             CLR,
   input  logic             EN,
   input  logic             LOAD,
   input  logic [WIDTH-1:0] D_IN,
   output logic [WIDTH-1:0] Q_OUT,
   output logic             BUSY,
   output logic             TC
);
   state_t           state;
   logic             term;
   logic [WIDTH-1:0] q_nxt;
   logic [WIDTH-1:0] term_val;
   countdown_fsm u_fsm (
      .CLK    (CLK),
      .CLR    (CLR),
      .EN     (EN),
      .LOAD   (LOAD),
      .d_zero (D_IN == '0),
      .q_one  (Q_OUT == WIDTH'(1)),
      .state  (state),
      .TC     (TC),
      .term   (term)
   );
`ifdef COUNTDOWN_AUTO_RELOAD_EN
   logic [WIDTH-1:0] reload;
   // reload register captures every loaded start value
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR)
         reload <= '0;
      else if (LOAD)
         reload <= D_IN;
   end
   assign term_val = reload;
`else
   assign term_val = '0;
`endif
   // count update; the Q_OUT > 1 guard keeps the count from ever wrapping below zero
   always_comb begin
      q_nxt = LOAD ? D_IN
            : term ? term_val
            : (state == RUN && EN && Q_OUT > WIDTH'(1)) ? Q_OUT - WIDTH'(1)
            : Q_OUT;
   end
   // count register, cleared asynchronously
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR)
         Q_OUT <= '0;
      else
         Q_OUT <= q_nxt;
   end
   assign BUSY = (state == RUN);
endmodule

// File: tb/tb_countdown_4bit.sv
// tb_countdown_4bit: scoreboard bench for countdown_4bit (honours COUNTDOWN_AUTO_RELOAD_EN)
module tb_countdown_4bit;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif
   typedef struct {
      logic [3:0] q;
      logic       busy;
      logic       tc;
      int         id;
   } exp_t;
   logic       CLK = 1'b0;
   logic       CLR, EN, LOAD;
   logic [3:0] D_IN;
   logic [3:0] Q_OUT;
   logic       BUSY, TC;
   exp_t       sb[$];
   int         checks = 0;
   int         errors = 0;
   int         nstep  = 0;
   countdown_4bit #(.WIDTH(4)) dut (
      .CLK   (CLK),
      .CLR   (CLR),
      .EN    (EN),
      .LOAD  (LOAD),
      .D_IN  (D_IN),
      .Q_OUT (Q_OUT),
      .BUSY  (BUSY),
      .TC    (TC)
   );
   always #5 CLK = ~CLK;
   function automatic logic [3:0] rv(input logic [3:0] v);
      return AR ? v : 4'd0;
   endfunction
   task automatic chk(input string name, input logic [3:0] q, input logic b, input logic t);
      checks++;
      if (Q_OUT !== q || BUSY !== b || TC !== t) begin
         errors++;
         $display("FAIL %s: got Q_OUT=%0d BUSY=%0b TC=%0b, expected Q_OUT=%0d BUSY=%0b TC=%0b",
                  name, Q_OUT, BUSY, TC, q, b, t);
      end
   endtask
   task automatic step(input logic en, input logic ld, input logic [3:0] d,
                       input logic [3:0] eq, input logic eb, input logic et);
      @(negedge CLK);
      EN = en;
      LOAD = ld;
      D_IN = d;
      sb.push_back('{eq, eb, et, nstep});
      nstep++;
      @(posedge CLK);
   endtask
   task automatic clr_pulse(input string name);
      #2 CLR = 1'b1;
      #1 chk(name, 4'd0, 1'b0, 1'b0);
      @(negedge CLK);
      CLR = 1'b0;
      LOAD = 1'b0;
      EN = 1'b0;
   endtask
   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge CLK);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("step%0d", e.id), e.q, e.busy, e.tc);
         end
      end
   end
   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not complete, expected completion");
      $fatal(1, "timeout");
   end
   initial begin : stim
      int aq[9] = '{2, 1, 3, 2, 1, 3, 2, 1, 3};
      CLR = 1'b1;
      EN = 1'b0;
      LOAD = 1'b0;
      D_IN = 4'd0;
      #3 chk("reset", 4'd0, 1'b0, 1'b0);
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      CLR = 1'b0;
      step(1, 0, 0, 0, 0, 0);
      step(0, 1, 4, 4, 1, 0);
      step(1, 0, 0, 3, 1, 0);
      step(0, 0, 0, 3, 1, 0);
      step(1, 0, 0, 2, 1, 0);
      step(1, 0, 0, 1, 1, 0);
      step(1, 0, 0, rv(4), AR, 1);
      step(0, 0, 0, rv(4), AR, 0);
      step(0, 1, 3, 3, 1, 0);
      step(1, 0, 0, 2, 1, 0);
      step(1, 0, 0, 1, 1, 0);
      step(1, 0, 0, rv(3), AR, 1);
      step(0, 0, 0, rv(3), AR, 0);
      step(0, 1, 0, 0, 0, 0);
      repeat (5) step(1, 0, 0, 0, 0, 0);
      step(0, 1, 2, 2, 1, 0);
      step(1, 0, 0, 1, 1, 0);
      step(1, 1, 7, 7, 1, 0);
      step(1, 0, 0, 6, 1, 0);
      step(0, 1, 5, 5, 1, 0);
      clr_pulse("clr_mid_count");
      step(1, 0, 0, 0, 0, 0);
      step(0, 1, 1, 1, 1, 0);
      step(1, 0, 0, rv(1), AR, 1);
      clr_pulse("clr_during_tc");
      step(1, 0, 0, 0, 0, 0);
      if (AR) begin
         step(0, 1, 3, 3, 1, 0);
         for (int i = 0; i < 9; i++)
            step(1, 0, 0, 4'(aq[i]), 1, aq[i] == 3);
      end
      @(negedge CLK);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
